branch_rollback_issuer: RTL

Initiator side of the branch-rollback interface. Collects taken-branch resolutions from the execute-stage branch unit and buffers one pending rollback per thread. It arbitrates round-robin among threads and drives the bc_rollback_* / bc_scoreboard request consumed by the rollback handler. After each issued rollback it squashes further resolutions from that thread while the flushed, younger instructions drain.

---
 rtl/branch_rollback_issuer_if.sv | 40 ++++
 rtl/branch_rollback_issuer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/branch_rollback_issuer_if.sv
// Branch-rollback bus: execute-stage resolutions in, rollback requests out.
// master = issuer side, slave = branch unit / rollback handler side.
interface branch_rollback_issuer_if #(
  parameter int THREAD_NUMB = 8,
  parameter int ADDR_W      = 32,
  parameter int SB_W        = 64,
  parameter int CNT_W       = 16
);
  localparam int TID_W = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1;

  logic                   ex_valid;
  logic [TID_W-1:0]       ex_thread_id;
  logic                   ex_taken;
  logic [ADDR_W-1:0]      ex_target_pc;
  logic [SB_W-1:0]        ex_scoreboard;
  logic [THREAD_NUMB-1:0] ext_flush;

  logic                   bc_rollback_enable;
  logic                   bc_rollback_valid;
  logic [ADDR_W-1:0]      bc_rollback_pc;
  logic [TID_W-1:0]       bc_rollback_thread_id;
  logic [SB_W-1:0]        bc_scoreboard;
  logic [THREAD_NUMB-1:0] squash_mask;
  logic [CNT_W-1:0]       perf_rollbacks;
  logic [CNT_W-1:0]       perf_dropped;

  modport master (
    input  ex_valid, ex_thread_id, ex_taken, ex_target_pc, ex_scoreboard, ext_flush,
    output bc_rollback_enable, bc_rollback_valid, bc_rollback_pc,
           bc_rollback_thread_id, bc_scoreboard, squash_mask,
           perf_rollbacks, perf_dropped
  );

  modport slave (
    output ex_valid, ex_thread_id, ex_taken, ex_target_pc, ex_scoreboard, ext_flush,
    input  bc_rollback_enable, bc_rollback_valid, bc_rollback_pc,
           bc_rollback_thread_id, bc_scoreboard, squash_mask,
           perf_rollbacks, perf_dropped
  );
endinterface

// File: rtl/branch_rollback_issuer.sv
// Buffers one taken-branch rollback per thread, issues them round-robin and squashes
// a thread's later resolutions for FLUSH_WINDOW cycles. Optional macro: ROLLBACK_PERF_CNT_EN.
module branch_rollback_issuer #(
  parameter int THREAD_NUMB  = 8,
  parameter int ADDR_W       = 32,
  parameter int SB_W         = 64,
  parameter int FLUSH_WINDOW = 3,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  branch_rollback_issuer_if.master    bus
);
  localparam int         TID_W   = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1;
  localparam logic [3:0] SQ_LOAD = 4'(FLUSH_WINDOW);

  logic [THREAD_NUMB-1:0]             pend_v_all;
  logic [THREAD_NUMB-1:0]             squash_all;
  logic [THREAD_NUMB-1:0][ADDR_W-1:0] pend_pc_all;
  logic [THREAD_NUMB-1:0][SB_W-1:0]   pend_sb_all;

  logic [TID_W-1:0] rr_last_q;
  logic [TID_W-1:0] rr_last_d;
  logic             grant_valid;
  logic [TID_W-1:0] grant_id;
  logic [TID_W:0]   scan_sum;
  logic [TID_W-1:0] scan_idx;
  logic             consume_any;

  // Rotating priority search, starting one past the last consumed thread.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int i = 1; i <= THREAD_NUMB; i++) begin
      scan_sum = {1'b0, rr_last_q} + (TID_W+1)'(i);
      if (scan_sum >= (TID_W+1)'(THREAD_NUMB)) begin
        scan_sum = scan_sum - (TID_W+1)'(THREAD_NUMB);
      end
      scan_idx = scan_sum[TID_W-1:0];
      if (!grant_valid && pend_v_all[scan_idx]) begin
        grant_valid = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // An external flush of the granted thread pre-empts our own consumption.
  assign consume_any = enable & grant_valid & ~bus.ext_flush[grant_id];

  always_comb begin
    rr_last_d = rr_last_q;
    if (consume_any) begin
      rr_last_d = grant_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= TID_W'(THREAD_NUMB - 1);
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

`ifdef ROLLBACK_PERF_CNT_EN
  logic [THREAD_NUMB-1:0] drop_vec;
`endif

  for (genvar gi = 0; gi < THREAD_NUMB; gi++) begin : g_thread
    logic              pend_v_q;
    logic              pend_v_d;
    logic [ADDR_W-1:0] pend_pc_q;
    logic [ADDR_W-1:0] pend_pc_d;
    logic [SB_W-1:0]   pend_sb_q;
    logic [SB_W-1:0]   pend_sb_d;
    logic [3:0]        sq_cnt_q;
    logic [3:0]        sq_cnt_d;
    logic              flush;
    logic              taken_hit;
    logic              blocked;
    logic              capture;
    logic              consume;

    always_comb begin
      flush     = bus.ext_flush[gi];
      taken_hit = bus.ex_valid & bus.ex_taken & (bus.ex_thread_id == TID_W'(gi));
      // A younger result loses to an older pending entry or an open squash window.
      blocked   = (sq_cnt_q != 4'd0) | pend_v_q | flush;
      capture   = enable & taken_hit & ~blocked;
      consume   = consume_any & (grant_id == TID_W'(gi));

      pend_v_d  = pend_v_q;
      pend_pc_d = pend_pc_q;
      pend_sb_d = pend_sb_q;
      sq_cnt_d  = sq_cnt_q;

      if (enable) begin
        if (flush || consume) begin
          pend_v_d = 1'b0;
        end else if (capture) begin
          pend_v_d  = 1'b1;
          pend_pc_d = bus.ex_target_pc;
          pend_sb_d = bus.ex_scoreboard;
        end

        if (flush || consume) begin
          sq_cnt_d = SQ_LOAD;
        end else if (sq_cnt_q != 4'd0) begin
          sq_cnt_d = sq_cnt_q - 4'd1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pend_v_q  <= 1'b0;
        pend_pc_q <= '0;
        pend_sb_q <= '0;
        sq_cnt_q  <= 4'd0;
      end else begin
        pend_v_q  <= pend_v_d;
        pend_pc_q <= pend_pc_d;
        pend_sb_q <= pend_sb_d;
        sq_cnt_q  <= sq_cnt_d;
      end
    end

    assign pend_v_all[gi]  = pend_v_q;
    assign pend_pc_all[gi] = pend_pc_q;
    assign pend_sb_all[gi] = pend_sb_q;
    assign squash_all[gi]  = (sq_cnt_q != 4'd0);
`ifdef ROLLBACK_PERF_CNT_EN
    assign drop_vec[gi]    = enable & taken_hit & blocked;
`endif
  end

  assign bus.bc_rollback_enable    = grant_valid;
  assign bus.bc_rollback_valid     = grant_valid;
  assign bus.bc_rollback_thread_id = grant_valid ? grant_id : '0;
  assign bus.bc_rollback_pc        = grant_valid ? pend_pc_all[grant_id] : '0;
  assign bus.bc_scoreboard         = grant_valid ? pend_sb_all[grant_id] : '0;
  assign bus.squash_mask           = squash_all;

`ifdef ROLLBACK_PERF_CNT_EN
  logic [CNT_W-1:0] perf_rollbacks_q;
  logic [CNT_W-1:0] perf_rollbacks_d;
  logic [CNT_W-1:0] perf_dropped_q;
  logic [CNT_W-1:0] perf_dropped_d;

  // Only one resolution arrives per cycle, so at most one drop per cycle.
  always_comb begin
    perf_rollbacks_d = perf_rollbacks_q;
    perf_dropped_d   = perf_dropped_q;
    if (consume_any && !(&perf_rollbacks_q)) begin
      perf_rollbacks_d = perf_rollbacks_q + CNT_W'(1);
    end
    if ((|drop_vec) && !(&perf_dropped_q)) begin
      perf_dropped_d = perf_dropped_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rollbacks_q <= '0;
      perf_dropped_q   <= '0;
    end else begin
      perf_rollbacks_q <= perf_rollbacks_d;
      perf_dropped_q   <= perf_dropped_d;
    end
  end

  assign bus.perf_rollbacks = perf_rollbacks_q;
  assign bus.perf_dropped   = perf_dropped_q;
`else
  assign bus.perf_rollbacks = {CNT_W{1'b0}};
  assign bus.perf_dropped   = {CNT_W{1'b0}};
`endif
endmodule
